// File: rtl/lsu_lbuff_ret_module.sv
// Load-buffer retirement tracker: mirrors the dispatch allocator's pointers, tracks done/commit
// per entry and retires completed loads strictly in order, up to four per cycle.
module lsu_lbuff_ret_module #(
    parameter int LDQ_DEPTH = 32,
    parameter int LDQ_ID_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_csr_trap_flush,
    input  logic                i_exu_ls_flush,
    input  logic                i_exu_mis_flush,
    input  logic                i_rob_mis_ld_vld,
    input  logic [LDQ_ID_W-1:0] i_rob_mis_ld_id,
    input  logic [3:0]          i_dsp_wr_vld,
    input  logic [LDQ_ID_W-1:0] i_dsp_wr_id_0,
    input  logic [LDQ_ID_W-1:0] i_dsp_wr_id_1,
    input  logic [LDQ_ID_W-1:0] i_dsp_wr_id_2,
    input  logic [LDQ_ID_W-1:0] i_dsp_wr_id_3,
    input  logic [1:0]          i_lsu_done_vld,
    input  logic [LDQ_ID_W-1:0] i_lsu_done_id_0,
    input  logic [LDQ_ID_W-1:0] i_lsu_done_id_1,
    input  logic [3:0]          i_rob_cmt_vld,
    input  logic [LDQ_ID_W-1:0] i_rob_cmt_id_0,
    input  logic [LDQ_ID_W-1:0] i_rob_cmt_id_1,
    input  logic [LDQ_ID_W-1:0] i_rob_cmt_id_2,
    input  logic [LDQ_ID_W-1:0] i_rob_cmt_id_3,
    output logic [3:0]          o_ldq_ret_vld,
    output logic [LDQ_ID_W-1:0] o_ldq_head_id,
    output logic [LDQ_ID_W-1:0] o_ldq_tail_id,
    output logic [LDQ_ID_W:0]   o_ldq_cnt
);
    localparam int CNT_W = LDQ_ID_W + 1;

    logic [LDQ_DEPTH-1:0] vld_q, done_q, cmt_q;
    logic [LDQ_DEPTH-1:0] vld_nxt, done_nxt, cmt_nxt;
    logic [LDQ_DEPTH-1:0] entry_ok;
    logic [LDQ_ID_W-1:0]  head_q, tail_q, head_nxt, tail_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
    logic [LDQ_ID_W-1:0]  wr_id [4];
    logic [LDQ_ID_W-1:0]  done_id [2];
    logic [LDQ_ID_W-1:0]  cmt_id [4];
    logic [3:0]           ret_vld;
    logic                 ret_chain;
    logic [2:0]           ret_num, wr_num;
    logic                 mis_fire;
    logic [LDQ_ID_W-1:0]  flush_span;

    function automatic logic [2:0] pop4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    assign wr_id[0]   = i_dsp_wr_id_0;
    assign wr_id[1]   = i_dsp_wr_id_1;
    assign wr_id[2]   = i_dsp_wr_id_2;
    assign wr_id[3]   = i_dsp_wr_id_3;
    assign done_id[0] = i_lsu_done_id_0;
    assign done_id[1] = i_lsu_done_id_1;
    assign cmt_id[0]  = i_rob_cmt_id_0;
    assign cmt_id[1]  = i_rob_cmt_id_1;
    assign cmt_id[2]  = i_rob_cmt_id_2;
    assign cmt_id[3]  = i_rob_cmt_id_3;

    assign entry_ok   = vld_q & done_q & cmt_q;
    assign mis_fire   = (i_exu_ls_flush | i_exu_mis_flush) & i_rob_mis_ld_vld;
    assign flush_span = tail_q - i_rob_mis_ld_id;
    assign ret_num    = pop4(ret_vld);
    assign wr_num     = pop4(i_dsp_wr_vld);

    // In-order scan from head: a slot retires only if every older slot in the window retires too.
    always_comb begin
        ret_vld   = '0;
        ret_chain = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ret_chain  = ret_chain & entry_ok[head_q + LDQ_ID_W'(k)];
            ret_vld[k] = ret_chain;
        end
    end

    always_comb begin
        vld_nxt  = vld_q;
        done_nxt = done_q;
        cmt_nxt  = cmt_q;
        for (int p = 0; p < 2; p++) begin
            if (i_lsu_done_vld[p] && vld_q[done_id[p]]) begin
                done_nxt[done_id[p]] = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (i_rob_cmt_vld[k] && vld_q[cmt_id[k]]) begin
                cmt_nxt[cmt_id[k]] = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (ret_vld[k]) begin
                vld_nxt[head_q + LDQ_ID_W'(k)]  = 1'b0;
                done_nxt[head_q + LDQ_ID_W'(k)] = 1'b0;
                cmt_nxt[head_q + LDQ_ID_W'(k)]  = 1'b0;
            end
        end
        if (!mis_fire) begin
            for (int k = 0; k < 4; k++) begin
                if (i_dsp_wr_vld[k]) begin
                    vld_nxt[wr_id[k]]  = 1'b1;
                    done_nxt[wr_id[k]] = 1'b0;
                    cmt_nxt[wr_id[k]]  = 1'b0;
                end
            end
        end else begin
            // Discard everything younger than the flush point, i.e. ids in [mis_ld_id, tail).
            for (int i = 0; i < LDQ_DEPTH; i++) begin
                if ((LDQ_ID_W'(i) - i_rob_mis_ld_id) < flush_span) begin
                    vld_nxt[i]  = 1'b0;
                    done_nxt[i] = 1'b0;
                    cmt_nxt[i]  = 1'b0;
                end
            end
        end
    end

    always_comb begin
        head_nxt = head_q + LDQ_ID_W'(ret_num);
        tail_nxt = tail_q + LDQ_ID_W'(wr_num);
        cnt_nxt  = cnt_q + CNT_W'(wr_num) - CNT_W'(ret_num);
        if (mis_fire) begin
            tail_nxt = i_rob_mis_ld_id;
            // An empty flush range must not collapse a full queue (head==tail) to zero.
            if (i_rob_mis_ld_id == tail_q) begin
                cnt_nxt = cnt_q - CNT_W'(ret_num);
            end else begin
                cnt_nxt = CNT_W'(i_rob_mis_ld_id - head_nxt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_csr_trap_flush) begin
            vld_q  <= '0;
            done_q <= '0;
            cmt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_nxt;
            done_q <= done_nxt;
            cmt_q  <= cmt_nxt;
            head_q <= head_nxt;
            tail_q <= tail_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    assign o_ldq_ret_vld = ret_vld;
    assign o_ldq_head_id = head_q;
    assign o_ldq_tail_id = tail_q;
    assign o_ldq_cnt     = cnt_q;

endmodule

// File: tb/tb_lsu_lbuff_ret_module.sv
// Bench for the load-buffer retirement tracker: per-cycle vectors with expected outputs
// queued on drive and checked one cycle later.
module tb_lsu_lbuff_ret_module;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_csr_trap_flush, i_exu_ls_flush, i_exu_mis_flush, i_rob_mis_ld_vld;
    logic [4:0] i_rob_mis_ld_id;
    logic [3:0] i_dsp_wr_vld;
    logic [4:0] i_dsp_wr_id_0, i_dsp_wr_id_1, i_dsp_wr_id_2, i_dsp_wr_id_3;
    logic [1:0] i_lsu_done_vld;
    logic [4:0] i_lsu_done_id_0, i_lsu_done_id_1;
    logic [3:0] i_rob_cmt_vld;
    logic [4:0] i_rob_cmt_id_0, i_rob_cmt_id_1, i_rob_cmt_id_2, i_rob_cmt_id_3;
    logic [3:0] o_ldq_ret_vld;
    logic [4:0] o_ldq_head_id, o_ldq_tail_id;
    logic [5:0] o_ldq_cnt;

    always #5 clk = ~clk;

    lsu_lbuff_ret_module #(.LDQ_DEPTH(32), .LDQ_ID_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_csr_trap_flush(i_csr_trap_flush), .i_exu_ls_flush(i_exu_ls_flush),
        .i_exu_mis_flush(i_exu_mis_flush), .i_rob_mis_ld_vld(i_rob_mis_ld_vld),
        .i_rob_mis_ld_id(i_rob_mis_ld_id), .i_dsp_wr_vld(i_dsp_wr_vld),
        .i_dsp_wr_id_0(i_dsp_wr_id_0), .i_dsp_wr_id_1(i_dsp_wr_id_1),
        .i_dsp_wr_id_2(i_dsp_wr_id_2), .i_dsp_wr_id_3(i_dsp_wr_id_3),
        .i_lsu_done_vld(i_lsu_done_vld), .i_lsu_done_id_0(i_lsu_done_id_0),
        .i_lsu_done_id_1(i_lsu_done_id_1), .i_rob_cmt_vld(i_rob_cmt_vld),
        .i_rob_cmt_id_0(i_rob_cmt_id_0), .i_rob_cmt_id_1(i_rob_cmt_id_1),
        .i_rob_cmt_id_2(i_rob_cmt_id_2), .i_rob_cmt_id_3(i_rob_cmt_id_3),
        .o_ldq_ret_vld(o_ldq_ret_vld), .o_ldq_head_id(o_ldq_head_id),
        .o_ldq_tail_id(o_ldq_tail_id), .o_ldq_cnt(o_ldq_cnt)
    );

    typedef struct {
        string      name;
        logic       rstn, trap, mis, ls, mis_vld;
        logic [4:0] mis_id;
        logic [3:0] wr;
        logic [4:0] wb;
        logic [1:0] dv;
        logic [4:0] d0, d1;
        logic [3:0] cv;
        logic [4:0] cb;
        logic [3:0] er;
        logic [4:0] eh, et;
        logic [5:0] ec;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] ret;
        logic [4:0] head, tail;
        logic [5:0] cnt;
    } exp_t;

    exp_t       sb[$];
    vec_t       tbl[$];
    int         checks   = 0;
    int         failures = 0;
    logic [4:0] sb_head  = '0;
    logic [5:0] sb_cnt   = '0;

    function automatic vec_t mk(input string nm, input logic [3:0] wr, input logic [4:0] wb,
                                input logic [1:0] dv, input logic [4:0] d0, input logic [4:0] d1,
                                input logic [3:0] cv, input logic [4:0] cb, input logic [3:0] er,
                                input logic [4:0] eh, input logic [4:0] et, input logic [5:0] ec);
        vec_t v;
        v.name = nm; v.rstn = 1'b1; v.trap = 1'b0; v.mis = 1'b0; v.ls = 1'b0;
        v.mis_vld = 1'b0; v.mis_id = '0;
        v.wr = wr; v.wb = wb; v.dv = dv; v.d0 = d0; v.d1 = d1; v.cv = cv; v.cb = cb;
        v.er = er; v.eh = eh; v.et = et; v.ec = ec;
        return v;
    endfunction

    // Ids are packed: a set slot takes base plus the number of set slots below it.
    function automatic logic [4:0] pk_id(input logic [4:0] base, input logic [3:0] mask, input int k);
        int r = 0;
        for (int j = 0; j < k; j++) if (mask[j]) r++;
        return base + 5'(r);
    endfunction

    task automatic cmp(input string vn, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%0h required=%0h", vn, fld, act, req);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sb.pop_front();
        cmp(e.name, "ret_vld", 32'(o_ldq_ret_vld), 32'(e.ret));
        cmp(e.name, "head",    32'(o_ldq_head_id), 32'(e.head));
        cmp(e.name, "tail",    32'(o_ldq_tail_id), 32'(e.tail));
        cmp(e.name, "cnt",     32'(o_ldq_cnt),     32'(e.cnt));
        sb_head = e.head;
        sb_cnt  = e.cnt;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t       e;
        logic [4:0] wid [4];
        logic [4:0] cid [4];
        for (int k = 0; k < 4; k++) begin
            wid[k] = pk_id(v.wb, v.wr, k);
            cid[k] = pk_id(v.cb, v.cv, k);
        end
        // Writing a live entry is a stimulus error, not a design error.
        if (v.rstn && !v.trap && !((v.mis || v.ls) && v.mis_vld)) begin
            for (int k = 0; k < 4; k++) begin
                if (v.wr[k] && (6'(wid[k] - sb_head) < sb_cnt)) begin
                    failures++;
                    $display("[TB] FAIL illegal_write %s id=%0d actual=live required=free", v.name, wid[k]);
                end
            end
        end
        rst_n            = v.rstn;
        i_csr_trap_flush = v.trap;
        i_exu_mis_flush  = v.mis;
        i_exu_ls_flush   = v.ls;
        i_rob_mis_ld_vld = v.mis_vld;
        i_rob_mis_ld_id  = v.mis_id;
        i_dsp_wr_vld     = v.wr;
        i_dsp_wr_id_0    = wid[0];
        i_dsp_wr_id_1    = wid[1];
        i_dsp_wr_id_2    = wid[2];
        i_dsp_wr_id_3    = wid[3];
        i_lsu_done_vld   = v.dv;
        i_lsu_done_id_0  = v.d0;
        i_lsu_done_id_1  = v.d1;
        i_rob_cmt_vld    = v.cv;
        i_rob_cmt_id_0   = cid[0];
        i_rob_cmt_id_1   = cid[1];
        i_rob_cmt_id_2   = cid[2];
        i_rob_cmt_id_3   = cid[3];
        e.name = v.name; e.ret = v.er; e.head = v.eh; e.tail = v.et; e.cnt = v.ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Allocate two, complete both, retire both: head moves by two every three cycles.
    task automatic advance(input int from, input int to);
        int h = from;
        while (h != to) begin
            applyStimulus(mk("adv_wr", 4'b0011, 5'(h), 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0,
                             4'b0000, 5'(h), 5'(h + 2), 6'd2));
            applyStimulus(mk("adv_dc", 4'b0000, 5'd0, 2'b11, 5'(h), 5'(h + 1), 4'b0011, 5'(h),
                             4'b0011, 5'(h), 5'(h + 2), 6'd2));
            applyStimulus(mk("adv_ret", 4'b0000, 5'd0, 2'b00, 5'd0, 5'd0, 4'b0000, 5'd0,
                             4'b0000, 5'(h + 2), 5'(h + 2), 6'd0));
            h = (h + 2) % 32;
        end
    endtask

    // Fill all 32 entries from an empty queue at id 0 and mark them done, none committed.
    task automatic fill32();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(mk("fill_wr", 4'hF, 5'(4 * i), 2'b00, 5'd0, 5'd0, 4'h0, 5'd0,
                             4'h0, 5'd0, 5'((4 * i + 4) % 32), 6'(4 * i + 4)));
        end
        for (int j = 0; j < 16; j++) begin
            applyStimulus(mk("fill_done", 4'h0, 5'd0, 2'b11, 5'(2 * j), 5'(2 * j + 1), 4'h0, 5'd0,
                             4'h0, 5'd0, 5'd0, 6'd32));
        end
    endtask

    task automatic drain(input int n);
        for (int j = 0; j < n; j++) begin
            applyStimulus(mk("drain", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'hF, 5'(4 * j),
                             4'hF, 5'(4 * j), 5'd0, 6'(32 - 4 * j)));
        end
    endtask

    initial begin
        vec_t v;

        v = mk("reset", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd0, 5'd0, 6'd0);
        v.rstn = 1'b0;
        tbl.push_back(v);
        tbl.push_back(mk("wr0_3",     4'hF, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0,    5'd0, 4'h0,    5'd0, 5'd4, 6'd4));
        tbl.push_back(mk("done01",    4'h0, 5'd0, 2'b11, 5'd0, 5'd1, 4'h0,    5'd0, 4'h0,    5'd0, 5'd4, 6'd4));
        tbl.push_back(mk("done23cmt", 4'h0, 5'd0, 2'b11, 5'd2, 5'd3, 4'hF,    5'd0, 4'hF,    5'd0, 5'd4, 6'd4));
        tbl.push_back(mk("retire4",   4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0,    5'd0, 4'h0,    5'd4, 5'd4, 6'd0));
        v = mk("trap_a", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd0, 5'd0, 6'd0);
        v.trap = 1'b1;
        tbl.push_back(v);
        tbl.push_back(mk("wr0_3b",    4'hF, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0,    5'd0, 4'h0,    5'd0, 5'd4, 6'd4));
        tbl.push_back(mk("dc01",      4'h0, 5'd0, 2'b11, 5'd0, 5'd1, 4'b0011, 5'd0, 4'b0011, 5'd0, 5'd4, 6'd4));
        tbl.push_back(mk("d23_c3",    4'h0, 5'd0, 2'b11, 5'd2, 5'd3, 4'b0001, 5'd3, 4'h0,    5'd2, 5'd4, 6'd2));
        tbl.push_back(mk("cmt2",      4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'b0001, 5'd2, 4'b0011, 5'd2, 5'd4, 6'd2));
        tbl.push_back(mk("retire23",  4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0,    5'd0, 4'h0,    5'd4, 5'd4, 6'd0));

        for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

        // Done on a not-yet-allocated id must not stick once the id is written.
        advance(4, 16);
        applyStimulus(mk("done_inv17", 4'h0, 5'd0, 2'b01, 5'd17, 5'd0, 4'h0, 5'd0, 4'h0, 5'd16, 5'd16, 6'd0));
        applyStimulus(mk("wr16_17", 4'b0011, 5'd16, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd16, 5'd18, 6'd2));
        applyStimulus(mk("d16_c1617", 4'h0, 5'd0, 2'b01, 5'd16, 5'd0, 4'b0011, 5'd16, 4'b0001, 5'd16, 5'd18, 6'd2));
        applyStimulus(mk("ret16", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd17, 5'd18, 6'd1));
        applyStimulus(mk("done17", 4'h0, 5'd0, 2'b01, 5'd17, 5'd0, 4'h0, 5'd0, 4'b0001, 5'd17, 5'd18, 6'd1));
        applyStimulus(mk("ret17", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd18, 5'd18, 6'd0));

        // Retire window wrapping past id 31.
        advance(18, 30);
        applyStimulus(mk("wr30_1", 4'hF, 5'd30, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd30, 5'd2, 6'd4));
        applyStimulus(mk("d3031", 4'h0, 5'd0, 2'b11, 5'd30, 5'd31, 4'h0, 5'd0, 4'h0, 5'd30, 5'd2, 6'd4));
        applyStimulus(mk("d01_cmt", 4'h0, 5'd0, 2'b11, 5'd0, 5'd1, 4'hF, 5'd30, 4'hF, 5'd30, 5'd2, 6'd4));
        applyStimulus(mk("wrap", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd2, 5'd2, 6'd0));

        // Holey dispatch masks, then a mispredict flush at id 9 with same-cycle writes.
        advance(2, 4);
        applyStimulus(mk("wr_hole4", 4'b0100, 5'd4, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd4, 5'd5, 6'd1));
        applyStimulus(mk("dc4", 4'h0, 5'd0, 2'b01, 5'd4, 5'd0, 4'b0001, 5'd4, 4'b0001, 5'd4, 5'd5, 6'd1));
        applyStimulus(mk("ret4", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd5, 5'd5, 6'd0));
        applyStimulus(mk("wr5_8", 4'hF, 5'd5, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd5, 5'd9, 6'd4));
        applyStimulus(mk("wr9_10", 4'b1010, 5'd9, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd5, 5'd11, 6'd6));
        applyStimulus(mk("wr11_12", 4'b0011, 5'd11, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd5, 5'd13, 6'd8));
        applyStimulus(mk("dc9_12", 4'h0, 5'd0, 2'b11, 5'd9, 5'd10, 4'hF, 5'd9, 4'h0, 5'd5, 5'd13, 6'd8));
        applyStimulus(mk("d11_12", 4'h0, 5'd0, 2'b11, 5'd11, 5'd12, 4'h0, 5'd0, 4'h0, 5'd5, 5'd13, 6'd8));
        v = mk("mis_flush9", 4'b0011, 5'd13, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd5, 5'd9, 6'd4);
        v.mis = 1'b1; v.mis_vld = 1'b1; v.mis_id = 5'd9;
        applyStimulus(v);
        applyStimulus(mk("dc5_8", 4'h0, 5'd0, 2'b11, 5'd5, 5'd6, 4'hF, 5'd5, 4'b0011, 5'd5, 5'd9, 6'd4));
        applyStimulus(mk("d7_8", 4'h0, 5'd0, 2'b11, 5'd7, 5'd8, 4'h0, 5'd0, 4'b0011, 5'd7, 5'd9, 6'd2));
        applyStimulus(mk("flushed_gone", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd9, 5'd9, 6'd0));

        // Load/store-order flush: ignored without a load id, effective with one.
        v = mk("ls_novld", 4'b0011, 5'd9, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd9, 5'd11, 6'd2);
        v.ls = 1'b1; v.mis_id = 5'd9;
        applyStimulus(v);
        v = mk("ls_flush10", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd9, 5'd10, 6'd1);
        v.ls = 1'b1; v.mis_vld = 1'b1; v.mis_id = 5'd10;
        applyStimulus(v);
        applyStimulus(mk("dc9", 4'h0, 5'd0, 2'b01, 5'd9, 5'd0, 4'b0001, 5'd9, 4'b0001, 5'd9, 5'd10, 6'd1));
        applyStimulus(mk("ret9", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd10, 5'd10, 6'd0));

        // Full queue drained at four per cycle.
        v = mk("trap_b", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd0, 5'd0, 6'd0);
        v.trap = 1'b1;
        applyStimulus(v);
        fill32();
        drain(8);
        applyStimulus(mk("drained", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd0, 5'd0, 6'd0));

        // Trap flush in the middle of a drain.
        fill32();
        drain(4);
        v = mk("trap_mid", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd0, 5'd0, 6'd0);
        v.trap = 1'b1;
        applyStimulus(v);
        applyStimulus(mk("post_trap", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd0, 5'd0, 6'd0));

        // Reset in the middle of a drain.
        fill32();
        drain(3);
        v = mk("rst_mid", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd0, 5'd0, 6'd0);
        v.rstn = 1'b0;
        applyStimulus(v);
        applyStimulus(mk("post_rst", 4'h0, 5'd0, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd0, 5'd0, 6'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
